// File: rtl/axi_test_reg_csr.sv
// rtl/axi_test_reg_csr.sv - AXI4-Lite register block for the axi_test_reg map
// REGISTER_0/1 are RW field flops, REGISTER_2 reflects hardware status inputs.

package axi_test_reg_rtl_pkg;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [7:0] REGISTER_0_ADDR = 8'h00;
  localparam logic [7:0] REGISTER_1_ADDR = 8'h04;
  localparam logic [7:0] REGISTER_2_ADDR = 8'h08;

  localparam logic [5:0] REGISTER_0_IDX = REGISTER_0_ADDR[7:2];
  localparam logic [5:0] REGISTER_1_IDX = REGISTER_1_ADDR[7:2];
  localparam logic [5:0] REGISTER_2_IDX = REGISTER_2_ADDR[7:2];

  localparam int unsigned REGISTER_0_WIDTH = 17;
  localparam logic [31:0] REGISTER_0_MASK = 32'h0001_FFFF;
  localparam logic [31:0] REGISTER_1_MASK = 32'h0000_0001;
  localparam logic [31:0] REGISTER_2_MASK = 32'h000F_FF0F;

  localparam int unsigned REG0_F0_OFFSET = 0;
  localparam int unsigned REG0_F0_WIDTH  = 4;
  localparam int unsigned REG0_F1_OFFSET = 4;
  localparam int unsigned REG0_F1_WIDTH  = 4;
  localparam int unsigned REG0_F2_OFFSET = 8;
  localparam int unsigned REG0_F3_OFFSET = 9;
  localparam int unsigned REG0_F3_WIDTH  = 2;
  localparam int unsigned REG0_F4_OFFSET = 11;
  localparam int unsigned REG0_F4_WIDTH  = 2;
  localparam int unsigned REG0_F5_OFFSET = 13;
  localparam int unsigned REG0_F5_WIDTH  = 2;
  localparam int unsigned REG0_F6_OFFSET = 15;
  localparam int unsigned REG0_F6_WIDTH  = 2;

  localparam int unsigned REG2_F0_OFFSET = 0;
  localparam int unsigned REG2_F0_WIDTH  = 4;
  localparam int unsigned REG2_F1_OFFSET = 8;
  localparam int unsigned REG2_F1_WIDTH  = 8;
  localparam int unsigned REG2_F2_OFFSET = 16;
  localparam int unsigned REG2_F2_WIDTH  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

module axi_test_reg_csr
  import axi_test_reg_rtl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DATA_W-1:0] s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        s_rresp,
  output logic [3:0]        o_reg0_f0,
  output logic [3:0]        o_reg0_f1,
  output logic              o_reg0_f2,
  output logic [1:0]        o_reg0_f3,
  output logic [1:0]        o_reg0_f4,
  output logic [1:0]        o_reg0_f5,
  output logic [1:0]        o_reg0_f6,
  output logic              o_reg1,
  input  logic [3:0]        i_reg2_f0,
  input  logic [7:0]        i_reg2_f1,
  input  logic [3:0]        i_reg2_f2
);

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic                        wr_accept;
  logic                        rd_accept;
  logic [5:0]                  wr_idx;
  logic [5:0]                  rd_idx;
  logic                        wr_hit0;
  logic                        wr_hit1;
  logic                        wr_err;
  logic [DATA_W-1:0]           wmask;
  logic [REGISTER_0_WIDTH-1:0] reg0_q;
  logic [REGISTER_0_WIDTH-1:0] reg0_nxt;
  logic                        reg1_q;
  logic [DATA_W-1:0]           rd_word;
  logic [1:0]                  rd_resp;
  logic                        unused_bits;

  // Only addr[7:2] and the low 17 data bits carry meaning.
  assign unused_bits = ^{s_awaddr, s_araddr, s_wdata, wmask};

  // ---------------- write channel ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) w_state <= W_IDLE;
    else       w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    wr_accept   = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_awvalid && s_wvalid) begin
          wr_accept   = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign s_awready = wr_accept;
  assign s_wready  = wr_accept;
  assign s_bvalid  = (w_state == W_RESP);

  assign wr_idx  = s_awaddr[7:2];
  assign wr_hit0 = (wr_idx == REGISTER_0_IDX);
  assign wr_hit1 = (wr_idx == REGISTER_1_IDX);
  assign wr_err  = !(wr_hit0 || wr_hit1);

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[b*8 +: 8] = {8{s_wstrb[b]}};
    end
  end

  // Bit 15 and bit 16 of field 6 follow different strobe lanes naturally here.
  assign reg0_nxt = (reg0_q & ~wmask[REGISTER_0_WIDTH-1:0]) |
                    (s_wdata[REGISTER_0_WIDTH-1:0] & wmask[REGISTER_0_WIDTH-1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      reg0_q  <= '0;
      reg1_q  <= 1'b0;
      s_bresp <= RESP_OKAY;
    end else if (wr_accept) begin
      s_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (wr_hit0) reg0_q <= reg0_nxt;
      if (wr_hit1 && s_wstrb[0]) reg1_q <= s_wdata[0];
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= R_IDLE;
    else       r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    rd_accept   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (s_arvalid) begin
          rd_accept   = 1'b1;
          r_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign s_arready = rd_accept;
  assign s_rvalid  = (r_state == R_DATA);
  assign rd_idx    = s_araddr[7:2];

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      REGISTER_0_IDX: rd_word[REGISTER_0_WIDTH-1:0] = reg0_q;
      REGISTER_1_IDX: rd_word[0] = reg1_q;
      REGISTER_2_IDX: begin
        rd_word[REG2_F0_OFFSET +: REG2_F0_WIDTH] = i_reg2_f0;
        rd_word[REG2_F1_OFFSET +: REG2_F1_WIDTH] = i_reg2_f1;
        rd_word[REG2_F2_OFFSET +: REG2_F2_WIDTH] = i_reg2_f2;
      end
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  // Sampled at the accept edge, so a same-cycle write is not yet visible.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else if (rd_accept) begin
      s_rdata <= rd_word;
      s_rresp <= rd_resp;
    end
  end

  // ---------------- field outputs ----------------
  assign o_reg0_f0 = reg0_q[REG0_F0_OFFSET +: REG0_F0_WIDTH];
  assign o_reg0_f1 = reg0_q[REG0_F1_OFFSET +: REG0_F1_WIDTH];
  assign o_reg0_f2 = reg0_q[REG0_F2_OFFSET];
  assign o_reg0_f3 = reg0_q[REG0_F3_OFFSET +: REG0_F3_WIDTH];
  assign o_reg0_f4 = reg0_q[REG0_F4_OFFSET +: REG0_F4_WIDTH];
  assign o_reg0_f5 = reg0_q[REG0_F5_OFFSET +: REG0_F5_WIDTH];
  assign o_reg0_f6 = reg0_q[REG0_F6_OFFSET +: REG0_F6_WIDTH];
  assign o_reg1    = reg1_q;

endmodule

// File: tb/tb_axi_test_reg_csr.sv
// tb/tb_axi_test_reg_csr.sv - scoreboard bench for axi_test_reg_csr
module tb_axi_test_reg_csr;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [7:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [3:0]  o_reg0_f0, o_reg0_f1;
  logic        o_reg0_f2, o_reg1;
  logic [1:0]  o_reg0_f3, o_reg0_f4, o_reg0_f5, o_reg0_f6;
  logic [3:0]  i_reg2_f0, i_reg2_f2;
  logic [7:0]  i_reg2_f1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic [1:0] bq[$];
  r_exp_t     rq[$];
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ar_cyc   = -100;
  int aw_cyc   = -100;
  logic rvalid_q = 1'b0;
  logic bvalid_q = 1'b0;

  axi_test_reg_csr #(.ADDR_W(8), .DATA_W(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .o_reg0_f0(o_reg0_f0), .o_reg0_f1(o_reg0_f1), .o_reg0_f2(o_reg0_f2),
    .o_reg0_f3(o_reg0_f3), .o_reg0_f4(o_reg0_f4), .o_reg0_f5(o_reg0_f5),
    .o_reg0_f6(o_reg0_f6), .o_reg1(o_reg1),
    .i_reg2_f0(i_reg2_f0), .i_reg2_f1(i_reg2_f1), .i_reg2_f2(i_reg2_f2)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_assert++;
    n_fail++;
    $display("FAIL %s: handshake did not complete within bound", name);
  endtask

  function automatic logic [31:0] reg0_image();
    return {15'b0, o_reg0_f6, o_reg0_f5, o_reg0_f4, o_reg0_f3, o_reg0_f2, o_reg0_f1, o_reg0_f0};
  endfunction

  // Monitor: pops expected responses on each completed B/R handshake
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (s_arvalid && s_arready) ar_cyc = cyc;
      if (s_awvalid && s_awready) aw_cyc = cyc;
      if (s_rvalid && !rvalid_q) check("r_latency", 32'(cyc - ar_cyc), 32'd1);
      if (s_bvalid && !bvalid_q) check("b_latency", 32'(cyc - aw_cyc), 32'd1);
      if (s_bvalid && s_bready) begin
        if (bq.size() == 0) timeout_fail("b_unexpected");
        else check("bresp", {30'b0, s_bresp}, {30'b0, bq.pop_front()});
      end
      if (s_rvalid && s_rready) begin
        if (rq.size() == 0) timeout_fail("r_unexpected");
        else begin
          r_exp_t e;
          e = rq.pop_front();
          check("rresp", {30'b0, s_rresp}, {30'b0, e.resp});
          check("rdata", s_rdata, e.data);
        end
      end
    end
    rvalid_q = s_rvalid;
    bvalid_q = s_bvalid;
  end

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] er);
    bit ok;
    ok = 1'b0;
    bq.push_back(er);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge i_clk);
      ok = s_awready && s_wready;
      @(posedge i_clk); #1;
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    if (!ok) begin bq.delete(); timeout_fail("aw_accept"); end
    for (int i = 0; i < 50 && bq.size() != 0; i++) @(posedge i_clk);
    #1;
    if (bq.size() != 0) begin bq.delete(); timeout_fail("b_drain"); end
  endtask

  task automatic do_read(input logic [7:0] a, input logic [1:0] er, input logic [31:0] ed);
    bit ok;
    ok = 1'b0;
    rq.push_back('{resp: er, data: ed});
    s_araddr = a;
    s_arvalid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge i_clk);
      ok = s_arready;
      @(posedge i_clk); #1;
    end
    s_arvalid = 1'b0;
    if (!ok) begin rq.delete(); timeout_fail("ar_accept"); end
    for (int i = 0; i < 50 && rq.size() != 0; i++) @(posedge i_clk);
    #1;
    if (rq.size() != 0) begin rq.delete(); timeout_fail("r_drain"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    s_awaddr = 0; s_araddr = 0; s_wdata = 0; s_wstrb = 0;
    s_bready = 1; s_rready = 1;
    i_reg2_f0 = 4'hA; i_reg2_f1 = 8'h5C; i_reg2_f2 = 4'h3;
    repeat (3) @(negedge i_clk);
    check("rst_valids", {28'b0, s_awready, s_wready, s_bvalid, s_rvalid}, 32'h0);
    check("rst_arready", {31'b0, s_arready}, 32'h0);
    check("rst_resp", {28'b0, s_bresp, s_rresp}, 32'h0);
    check("rst_rdata", s_rdata, 32'h0);
    check("rst_reg0", reg0_image(), 32'h0);
    check("rst_reg1", {31'b0, o_reg1}, 32'h0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // 1: reset readback
    do_read(8'h00, OKAY, 32'h0);
    do_read(8'h04, OKAY, 32'h0);
    do_read(8'h08, OKAY, 32'h0003_5C0A);

    // 2: full write
    do_write(8'h00, 32'hFFFF_FFFF, 4'hF, OKAY);
    do_read(8'h00, OKAY, 32'h0001_FFFF);
    check("t2_f0", {28'b0, o_reg0_f0}, 32'hF);
    check("t2_f2", {31'b0, o_reg0_f2}, 32'h1);
    check("t2_f6", {30'b0, o_reg0_f6}, 32'h3);

    // 3: lane 2 only clears bit 16
    do_write(8'h00, 32'h0, 4'b0100, OKAY);
    do_read(8'h00, OKAY, 32'h0000_FFFF);
    check("t3_f6", {30'b0, o_reg0_f6}, 32'h1);
    do_write(8'h03, 32'h0, 4'b0000, OKAY);
    do_read(8'h02, OKAY, 32'h0000_FFFF);

    // 4: REGISTER_1, RO write, unmapped
    do_write(8'h04, 32'h1, 4'hF, OKAY);
    check("t4_reg1", {31'b0, o_reg1}, 32'h1);
    do_write(8'h08, 32'hFFFF_FFFF, 4'hF, SLVERR);
    do_read(8'h08, OKAY, 32'h0003_5C0A);
    do_read(8'h0C, SLVERR, 32'h0);
    do_write(8'h40, 32'hFFFF_FFFF, 4'hF, SLVERR);
    do_read(8'h00, OKAY, 32'h0000_FFFF);
    check("t4_reg1_kept", {31'b0, o_reg1}, 32'h1);

    // same-cycle read and write to REGISTER_1: read sees pre-write value
    fork
      do_write(8'h04, 32'h0, 4'h1, OKAY);
      do_read(8'h04, OKAY, 32'h1);
    join
    check("rw_same_reg1", {31'b0, o_reg1}, 32'h0);

    // 5: B backpressure with a second write queued and a concurrent read
    s_bready = 1'b0;
    bq.push_back(OKAY);
    s_awaddr = 8'h04; s_wdata = 32'h0; s_wstrb = 4'h1;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge i_clk);
    check("t5_first_accept", {31'b0, s_awready}, 32'h1);
    @(posedge i_clk); #1;
    bq.push_back(OKAY);
    s_awaddr = 8'h00; s_wdata = 32'h0000_1234; s_wstrb = 4'h3;
    fork
      do_read(8'h08, OKAY, 32'h0003_5C0A);
      for (int i = 0; i < 10; i++) begin
        @(negedge i_clk);
        check("t5_bvalid_held", {31'b0, s_bvalid}, 32'h1);
        check("t5_no_accept", {30'b0, s_awready, s_wready}, 32'h0);
        @(posedge i_clk);
      end
    join
    #1;
    s_bready = 1'b1;
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge i_clk);
        ok = s_awready && s_wready;
        @(posedge i_clk); #1;
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      if (!ok) timeout_fail("t5_second_accept");
      for (int i = 0; i < 20 && bq.size() != 0; i++) @(posedge i_clk);
      #1;
      if (bq.size() != 0) begin bq.delete(); timeout_fail("t5_b_drain"); end
    end
    check("t5_reg0", reg0_image(), 32'h0000_1234);
    check("t5_f3", {30'b0, o_reg0_f3}, 32'h1);
    check("t5_f4", {30'b0, o_reg0_f4}, 32'h2);
    do_read(8'h00, OKAY, 32'h0000_1234);

    // 6: reset with a read response and a write response pending
    do_write(8'h04, 32'h1, 4'h1, OKAY);
    s_rready = 1'b0; s_bready = 1'b0;
    s_araddr = 8'h00; s_arvalid = 1'b1;
    s_awaddr = 8'h00; s_wdata = 32'h0; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge i_clk);
    check("t6_accept", {30'b0, s_arready, s_awready}, 32'h3);
    @(posedge i_clk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge i_clk);
    check("t6_pending", {30'b0, s_rvalid, s_bvalid}, 32'h3);
    i_rst = 1'b1;
    #1;
    check("t6_valids_async", {30'b0, s_rvalid, s_bvalid}, 32'h0);
    @(negedge i_clk);
    check("t6_valids", {30'b0, s_rvalid, s_bvalid}, 32'h0);
    check("t6_reg0", reg0_image(), 32'h0);
    check("t6_reg1", {31'b0, o_reg1}, 32'h0);
    s_rready = 1'b1; s_bready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    do_read(8'h00, OKAY, 32'h0);
    do_read(8'h04, OKAY, 32'h0);

    repeat (2) @(posedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
